// File: rtl/eth_tx_pkt_builder.sv
// Ethernet TX packet builder: streams application payload bytes into the RMII
// transmitter's payload FIFO, zero-pads short frames, truncates long ones, then
// handshakes the transmission and enforces the inter-frame gap.
module eth_tx_pkt_builder #(
    parameter int unsigned pMIN_PAYLOAD      = 46,
    parameter int unsigned pMAX_PAYLOAD      = 1500,
    parameter int unsigned pIFG_CYCLES       = 48,
    parameter int unsigned pTX_START_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    input  logic        i_s_last,
    output logic        o_s_ready,
    input  logic        i_tx_en,
    output logic [7:0]  o_eth_byte,
    output logic        o_eth_byte_valid,
    output logic        o_eth_pkt_rdy,
    output logic [10:0] o_pkt_len,
    output logic        o_overflow,
    output logic        o_tx_timeout,
    output logic [15:0] o_pkt_cnt
);

    localparam int unsigned LP_TW = (pTX_START_TIMEOUT > 1) ? $clog2(pTX_START_TIMEOUT) : 1;
    localparam int unsigned LP_IW = (pIFG_CYCLES > 1) ? $clog2(pIFG_CYCLES) : 1;

    localparam logic [10:0]      LP_MIN     = 11'(pMIN_PAYLOAD);
    localparam logic [10:0]      LP_MAX     = 11'(pMAX_PAYLOAD);
    localparam logic [LP_TW-1:0] LP_TO_LAST = LP_TW'(pTX_START_TIMEOUT - 1);
    localparam logic [LP_IW-1:0] LP_IFG_LAST = LP_IW'(pIFG_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StPad,
        StArm,
        StWaitStart,
        StWaitEnd,
        StIfg
    } t_state;

    t_state            r_state, w_state_nxt;
    logic [10:0]       r_cnt, w_cnt_nxt;
    logic [LP_TW-1:0]  r_tcnt, w_tcnt_nxt;
    logic [LP_IW-1:0]  r_icnt, w_icnt_nxt;
    logic              r_tx_ok, w_tx_ok_nxt;

    logic [7:0]  r_eth_byte;
    logic        r_eth_byte_valid;
    logic        r_pkt_rdy;
    logic [10:0] r_pkt_len;
    logic        r_overflow;
    logic        r_tx_timeout;
    logic [15:0] r_pkt_cnt;

    logic        w_ready;
    logic        w_xfer;
    logic [10:0] w_cnt_inc;
    logic        w_wr;
    logic [7:0]  w_wr_data;
    logic        w_arm;
    logic        w_ovf;
    logic        w_tout;
    logic        w_done;

    assign w_ready   = (r_state == StIdle) || (r_state == StLoad) || (r_state == StDrain);
    assign w_xfer    = i_s_valid & w_ready;
    assign w_cnt_inc = r_cnt + 11'd1;

    // Next-state, FIFO write and pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tcnt_nxt  = r_tcnt;
        w_icnt_nxt  = r_icnt;
        w_tx_ok_nxt = r_tx_ok;
        w_wr        = 1'b0;
        w_wr_data   = i_s_data;
        w_arm       = 1'b0;
        w_ovf       = 1'b0;
        w_tout      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = 11'd1;
                    if (i_s_last) begin
                        w_state_nxt = (LP_MIN > 11'd1) ? StPad : StArm;
                    end else begin
                        w_state_nxt = StLoad;
                    end
                end
            end

            StLoad: begin
                if (w_xfer) begin
                    w_wr      = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    if (i_s_last) begin
                        w_state_nxt = (w_cnt_inc < LP_MIN) ? StPad : StArm;
                    end else if (w_cnt_inc == LP_MAX) begin
                        // Frame is full; the rest of this packet is swallowed
                        w_state_nxt = StDrain;
                    end
                end
            end

            StDrain: begin
                if (w_xfer && i_s_last) begin
                    w_ovf       = 1'b1;
                    w_state_nxt = StArm;
                end
            end

            StPad: begin
                w_wr      = 1'b1;
                w_wr_data = 8'h00;
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc >= LP_MIN) begin
                    w_state_nxt = StArm;
                end
            end

            StArm: begin
                w_arm       = 1'b1;
                w_tcnt_nxt  = '0;
                w_tx_ok_nxt = 1'b0;
                w_state_nxt = StWaitStart;
            end

            StWaitStart: begin
                if (i_tx_en) begin
                    w_state_nxt = StWaitEnd;
                end else if (r_tcnt == LP_TO_LAST) begin
                    // Transmitter never started: give up, but still honour the gap
                    w_tout      = 1'b1;
                    w_tx_ok_nxt = 1'b0;
                    w_icnt_nxt  = '0;
                    w_state_nxt = StIfg;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end

            StWaitEnd: begin
                if (!i_tx_en) begin
                    w_tx_ok_nxt = 1'b1;
                    w_icnt_nxt  = '0;
                    w_state_nxt = StIfg;
                end
            end

            StIfg: begin
                if (r_icnt == LP_IFG_LAST) begin
                    w_done      = r_tx_ok;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                end else begin
                    w_icnt_nxt = r_icnt + 1'b1;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_icnt  <= '0;
            r_tx_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_icnt  <= w_icnt_nxt;
            r_tx_ok <= w_tx_ok_nxt;
        end
    end

    // Registered FIFO write port, status pulses and packet statistics
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_eth_byte       <= '0;
            r_eth_byte_valid <= 1'b0;
            r_pkt_rdy        <= 1'b0;
            r_pkt_len        <= '0;
            r_overflow       <= 1'b0;
            r_tx_timeout     <= 1'b0;
            r_pkt_cnt        <= '0;
        end else begin
            r_eth_byte_valid <= w_wr;
            r_pkt_rdy        <= w_arm;
            r_overflow       <= w_ovf;
            r_tx_timeout     <= w_tout;
            if (w_wr) begin
                r_eth_byte <= w_wr_data;
                r_pkt_len  <= w_cnt_nxt;
            end
            if (w_done) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    // Ready is forced low while reset is held so every output reads 0
    assign o_s_ready        = w_ready & ~i_rst;
    assign o_eth_byte       = r_eth_byte;
    assign o_eth_byte_valid = r_eth_byte_valid;
    assign o_eth_pkt_rdy    = r_pkt_rdy;
    assign o_pkt_len        = r_pkt_len;
    assign o_overflow       = r_overflow;
    assign o_tx_timeout     = r_tx_timeout;
    assign o_pkt_cnt        = r_pkt_cnt;

endmodule

// File: tb/tb_eth_tx_pkt_builder.sv
// Self-checking bench for eth_tx_pkt_builder: table of directed packets, a
// reset-in-flight sequence and randomized packets checked against a model.
module tb_eth_tx_pkt_builder;

    localparam int MIN = 46;
    localparam int MAX = 1500;
    localparam int IFG = 48;
    localparam int TO  = 1024;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        tx_en;
    logic [7:0]  eth_byte;
    logic        eth_vld;
    logic        pkt_rdy;
    logic [10:0] pkt_len;
    logic        ovf;
    logic        tout;
    logic [15:0] pkt_cnt;

    eth_tx_pkt_builder #(
        .pMIN_PAYLOAD      (MIN),
        .pMAX_PAYLOAD      (MAX),
        .pIFG_CYCLES       (IFG),
        .pTX_START_TIMEOUT (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_s_data         (s_data),
        .i_s_valid        (s_valid),
        .i_s_last         (s_last),
        .o_s_ready        (s_ready),
        .i_tx_en          (tx_en),
        .o_eth_byte       (eth_byte),
        .o_eth_byte_valid (eth_vld),
        .o_eth_pkt_rdy    (pkt_rdy),
        .o_pkt_len        (pkt_len),
        .o_overflow       (ovf),
        .o_tx_timeout     (tout),
        .o_pkt_cnt        (pkt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: records every FIFO write and every status pulse, 1 ns after the edge
    logic [7:0] wr_q[$];
    int cyc = 0, last_wr_cyc = 0, rdy_cyc = 0, tout_cyc = 0;
    int rdy_cnt = 0, ovf_cnt = 0, tout_cnt = 0;
    bit prev_rdy = 0, prev_ovf = 0, prev_tout = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (eth_vld) begin
            wr_q.push_back(eth_byte);
            last_wr_cyc = cyc;
        end
        if (pkt_rdy) begin
            rdy_cnt++;
            rdy_cyc = cyc;
            chk("pkt_rdy_single_cycle", int'(prev_rdy), 0);
        end
        if (ovf) begin
            ovf_cnt++;
            chk("overflow_single_cycle", int'(prev_ovf), 0);
        end
        if (tout) begin
            tout_cnt++;
            tout_cyc = cyc;
            chk("timeout_single_cycle", int'(prev_tout), 0);
        end
        prev_rdy  = pkt_rdy;
        prev_ovf  = ovf;
        prev_tout = tout;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] pkt_data[$];
    int exp_cnt = 0;

    task automatic fill_ramp(input int len, input int base);
        pkt_data.delete();
        for (int j = 0; j < len; j++) pkt_data.push_back(8'(base + j));
    endtask

    task automatic fill_rand(input int len);
        pkt_data.delete();
        for (int j = 0; j < len; j++) pkt_data.push_back(8'($urandom));
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random
    task automatic send(input int len, input int mode, output bit ok);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit v;
        while (i < len && guard < 8 * len + 100) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       begin v = ph; ph = ~ph; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            if (v) begin
                s_data = pkt_data[i];
                s_last = (i == len - 1);
            end else begin
                s_data = 8'($urandom);
                s_last = 1'($urandom_range(0, 1));
            end
            if (v && s_ready) i++;
            guard++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        ok = (i == len);
    endtask

    task automatic run_pkt(input int len, input int mode, input int tmo,
                           input int exp_len, input int exp_ovf);
        int wr0, rdy0, ovf0, tout0, guard, mism, zeros, k;
        bit ok;
        logic [7:0] exp_q[$];
        wr0   = wr_q.size();
        rdy0  = rdy_cnt;
        ovf0  = ovf_cnt;
        tout0 = tout_cnt;
        // Expected FIFO image: payload up to the max, then zeros up to the min
        for (int j = 0; j < exp_len; j++)
            exp_q.push_back((j < len && j < MAX) ? pkt_data[j] : 8'h00);

        send(len, mode, ok);
        chk("send_complete", int'(ok), 1);
        guard = 0;
        while (rdy_cnt == rdy0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk("pkt_rdy_pulses", rdy_cnt - rdy0, 1);
        chk("write_count", wr_q.size() - wr0, exp_len);
        mism = 0;
        for (int j = 0; j < exp_len && wr0 + j < wr_q.size(); j++)
            if (wr_q[wr0 + j] !== exp_q[j]) mism++;
        chk("write_data_mismatches", mism, 0);
        if (exp_ovf == 0) chk("pkt_rdy_latency", rdy_cyc - last_wr_cyc, 1);
        chk("pkt_len", int'(pkt_len), exp_len);
        chk("overflow_pulses", ovf_cnt - ovf0, exp_ovf);
        chk("eth_byte_hold", int'(eth_byte), int'(exp_q[exp_len - 1]));
        chk("s_ready_after_arm", int'(s_ready), 0);

        if (tmo == 0) begin
            k = $urandom_range(1, 16);
            tx_en = 1'b1;
            repeat (k) @(negedge clk);
            tx_en = 1'b0;
            zeros = 0;
            @(negedge clk);
            while (!s_ready && zeros < 500) begin
                zeros++;
                @(negedge clk);
            end
            exp_cnt = (exp_cnt + 1) % 65536;
        end else begin
            guard = 0;
            while (tout_cnt == tout0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            chk("timeout_pulses", tout_cnt - tout0, 1);
            chk("timeout_latency", tout_cyc - rdy_cyc, TO);
            zeros = 0;
            while (!s_ready && zeros < 500) begin
                zeros++;
                @(negedge clk);
            end
        end
        chk("ifg_ready_low_cycles", zeros, IFG);
        chk("pkt_cnt", int'(pkt_cnt), exp_cnt);
        chk("pkt_len_hold", int'(pkt_len), exp_len);
    endtask

    typedef struct {
        int len;
        int mode;
        int base;
        int tmo;
        int exp_len;
        int exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int len, mode, el, eo, n;
        bit ok;
        vecs[0] = '{64,   0, 'h00, 0, 64,   0};
        vecs[1] = '{10,   0, 'hA0, 0, 46,   0};
        vecs[2] = '{1600, 0, 'h00, 0, 1500, 1};
        vecs[3] = '{46,   1, 'h30, 0, 46,   0};
        vecs[4] = '{20,   0, 'h55, 1, 46,   0};
        vecs[5] = '{1,    0, 'h7E, 0, 46,   0};
        vecs[6] = '{45,   2, 'h10, 0, 46,   0};
        vecs[7] = '{47,   0, 'h20, 0, 47,   0};
        vecs[8] = '{1500, 0, 'h01, 0, 1500, 0};
        vecs[9] = '{1501, 0, 'h02, 0, 1500, 1};

        rst     = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        tx_en   = 1'b0;
        #1 rst  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", int'(s_ready), 0);
        chk("reset_pkt_cnt", int'(pkt_cnt), 0);
        chk("reset_pkt_len", int'(pkt_len), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", int'(s_ready), 1);
        chk("idle_eth_byte_valid", int'(eth_vld), 0);

        foreach (vecs[v]) begin
            fill_ramp(vecs[v].len, vecs[v].base);
            run_pkt(vecs[v].len, vecs[v].mode, vecs[v].tmo, vecs[v].exp_len, vecs[v].exp_ovf);
        end

        // Reset while loading byte 20 of a 64-byte packet
        fill_ramp(64, 0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = pkt_data[n];
            s_last  = 1'b0;
            if (s_ready) n++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst  = 1'b1;
        #1;
        chk("midrst_s_ready", int'(s_ready), 0);
        chk("midrst_eth_byte", int'(eth_byte), 0);
        chk("midrst_eth_byte_valid", int'(eth_vld), 0);
        chk("midrst_pkt_rdy", int'(pkt_rdy), 0);
        chk("midrst_pkt_len", int'(pkt_len), 0);
        chk("midrst_overflow", int'(ovf), 0);
        chk("midrst_timeout", int'(tout), 0);
        chk("midrst_pkt_cnt", int'(pkt_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        chk("postrst_s_ready", int'(s_ready), 1);
        fill_ramp(46, 'hC0);
        run_pkt(46, 0, 0, 46, 0);

        // Randomized packets against the length/pad/truncate rules
        for (int r = 0; r < 12; r++) begin
            len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1495, 1505))
                                                : int'($urandom_range(1, 120));
            mode = $urandom_range(0, 2);
            el   = (len > MAX) ? MAX : len;
            if (el < MIN) el = MIN;
            eo   = (len > MAX) ? 1 : 0;
            fill_rand(len);
            run_pkt(len, mode, (r == 7) ? 1 : 0, el, eo);
        end

        ok = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
